// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared run-state encoding and limits for the CPU run controller
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    START   = 3'd2,
    RUN     = 3'd3,
    DONE    = 3'd4,
    TIMEOUT = 3'd5
  } run_state_t;

  localparam int unsigned DEFAULT_MAX_CYCLES = 1000;

  // Width needed for a phase counter that runs 0..max(a,b)-1.
  function automatic int unsigned phase_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/run_watchdog.sv
// rtl/run_watchdog.sv - saturating run-cycle counter with limit detection
module run_watchdog #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LIMIT = 1001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  // Stops at LIMIT, so the counter can never wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT_V)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign hit = (count == LIMIT_V);

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - sequences CPU reset/start/run and reports done or watchdog timeout
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned START_CYCLES = 1,
  parameter int unsigned MAX_CYCLES   = DEFAULT_MAX_CYCLES,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             cpu_done,
  output logic             cpu_reset,
  output logic             cpu_start,
  output logic             busy,
  output logic             finished,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned PH_W = phase_w(RESET_CYCLES, START_CYCLES);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(RESET_CYCLES - 1);
  localparam logic [PH_W-1:0] START_LAST = PH_W'(START_CYCLES - 1);

  if ((64'(MAX_CYCLES) + 64'd1) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("cpu_run_ctrl: CNT_W too small to hold MAX_CYCLES+1");
  end
  if (RESET_CYCLES == 0 || START_CYCLES == 0) begin : g_bad_phase
    $error("cpu_run_ctrl: RESET_CYCLES and START_CYCLES must be non-zero");
  end

  run_state_t      state, state_nxt;
  logic [PH_W-1:0] phase, phase_nxt;
  logic            wd_clear, wd_en, wd_hit;

  run_watchdog #(
    .CNT_W (CNT_W),
    .LIMIT (MAX_CYCLES + 1)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_en),
    .count  (cycle_count),
    .hit    (wd_hit)
  );

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    wd_clear  = 1'b0;
    wd_en     = 1'b0;
    case (state)
      IDLE, DONE, TIMEOUT: begin
        if (go) begin
          state_nxt = HOLD;
          phase_nxt = '0;
          wd_clear  = 1'b1;
        end
      end
      HOLD: begin
        if (phase == HOLD_LAST) begin
          state_nxt = START;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end
      START: begin
        // The count steps on the edge into RUN so the first RUN cycle shows 1.
        if (phase == START_LAST) begin
          state_nxt = RUN;
          phase_nxt = '0;
          wd_en     = 1'b1;
        end else begin
          phase_nxt = phase + PH_W'(1);
        end
      end
      RUN: begin
        if (cpu_done) begin
          state_nxt = DONE;
        end else if (wd_hit) begin
          state_nxt = TIMEOUT;
        end else begin
          wd_en = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in step with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      cpu_reset <= 1'b1;
      cpu_start <= 1'b0;
      busy      <= 1'b0;
      finished  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      cpu_reset <= (state_nxt == IDLE) || (state_nxt == HOLD) || (state_nxt == TIMEOUT);
      cpu_start <= (state_nxt == START);
      busy      <= (state_nxt == HOLD) || (state_nxt == START) || (state_nxt == RUN);
      finished  <= (state_nxt == DONE);
      timeout   <= (state_nxt == TIMEOUT);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - randomized self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int RC   = 2;
  localparam int SC   = 1;
  localparam int MAXC = DEFAULT_MAX_CYCLES;
  localparam int LIM  = MAXC + 1;

  logic        clk = 1'b0;
  logic        reset, go, cpu_done;
  logic        cpu_reset, cpu_start, busy, finished, timeout;
  logic [15:0] cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  cpu_run_ctrl #(
    .RESET_CYCLES (RC),
    .START_CYCLES (SC),
    .MAX_CYCLES   (MAXC),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .cpu_done    (cpu_done),
    .cpu_reset   (cpu_reset),
    .cpu_start   (cpu_start),
    .busy        (busy),
    .finished    (finished),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int rst, input int st, input int bsy,
                            input int fin, input int to, input int cnt);
    check({tag, " cpu_reset"}, int'(cpu_reset), rst);
    check({tag, " cpu_start"}, int'(cpu_start), st);
    check({tag, " busy"}, int'(busy), bsy);
    check({tag, " finished"}, int'(finished), fin);
    check({tag, " timeout"}, int'(timeout), to);
    check({tag, " cycle_count"}, int'(cycle_count), cnt);
  endtask

  // One complete run from an idle/finished controller. done_at is the RUN cycle
  // (1-based) on which cpu_done rises; anything beyond LIM means the CPU hangs.
  task automatic run_once(input int done_at, input bit noise);
    bit last;
    bit hung;
    int exp_cnt;
    go = 1'b1;
    cpu_done = 1'b0;
    step();
    for (int i = 0; i < RC; i++) begin
      check_outs("hold", 1, 0, 1, 0, 0, 0);
      go       = noise ? 1'($urandom % 2) : 1'b0;
      cpu_done = noise ? 1'($urandom % 2) : 1'b0;
      step();
    end
    for (int i = 0; i < SC; i++) begin
      check_outs("start", 0, 1, 1, 0, 0, 0);
      go       = noise ? 1'($urandom % 2) : 1'b0;
      cpu_done = noise ? 1'($urandom % 2) : 1'b0;
      step();
    end
    for (int k = 1; k <= LIM; k++) begin
      check_outs("run", 0, 0, 1, 0, 0, k);
      cpu_done = (k == done_at);
      last     = (k == done_at) || (k == LIM);
      go       = (noise && !last) ? 1'($urandom % 2) : 1'b0;
      step();
      if (last) break;
    end
    cpu_done = 1'b0;
    hung     = (done_at > LIM);
    exp_cnt  = hung ? LIM : done_at;
    for (int i = 0; i < 2; i++) begin
      if (hung) check_outs("timeout", 1, 0, 0, 0, 1, exp_cnt);
      else      check_outs("done", 0, 0, 0, 1, 0, exp_cnt);
      step();
    end
  endtask

  initial begin
    reset    = 1'b1;
    go       = 1'b0;
    cpu_done = 1'b0;
    step();
    step();
    check_outs("reset", 1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    check_outs("idle", 1, 0, 0, 0, 0, 0);

    run_once(7, 1'b0);
    run_once(LIM + 5, 1'b0);
    run_once(LIM, 1'b0);
    run_once(MAXC, 1'b0);
    run_once(1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      run_once(int'($urandom_range(1, 60)), 1'b1);
    end

    // Abort in the middle of a run.
    go = 1'b1;
    step();
    go = 1'b0;
    for (int i = 0; i < RC + SC + 39; i++) step();
    check_outs("pre_abort", 0, 0, 1, 0, 0, 40);
    reset = 1'b1;
    step();
    check_outs("abort", 1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    check_outs("abort_idle", 1, 0, 0, 0, 0, 0);
    run_once(3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
